// File: rtl/sottrattore_seriale_pkg.sv
// Shared definitions for the bit-serial subtractor: state encodings and
// the step-counter width helper.
package sottrattore_seriale_pkg;

    // Control states of the serial subtractor. Encoding 2'd3 is unused and
    // falls back to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FINE = 2'd2
    } sott_state_e;

    localparam int SOTT_N_DEFAULT = 8;

    // Width of the bit-step counter: enough to hold 0..n-1, never zero.
    function automatic int sott_cnt_width(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sottrattore_seriale_1bit.sv
// Full subtractor cell: one difference bit and the borrow it generates.
module sottrattore_1bit (
    output logic d,
    output logic p_out,
    input  logic a,
    input  logic b,
    input  logic p_in
);

    // Difference bit and outgoing borrow for a - b - p_in.
    always_comb begin
        d     = a ^ b ^ p_in;
        p_out = (~a & b) | (~a & p_in) | (b & p_in);
    end

endmodule

// File: rtl/sottrattore_seriale.sv
// Bit-serial N-bit subtractor, d = a - b, one bit per clock, LSB first.
//
//  state   | meaning
//  --------+--------------------------------------------------------------
//  ST_IDLE | waiting for start; last result and flags held on the outputs
//  ST_CALC | one bit per cycle through the single full-subtractor cell
//  ST_FINE | done pulse; new result visible; start accepted again here
module sottrattore_seriale
    import sottrattore_seriale_pkg::*;
#(
    parameter int N = SOTT_N_DEFAULT
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] d,
    output logic         prestito,
    output logic         ovf
);

    localparam int CNT_W = sott_cnt_width(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    sott_state_e state;
    sott_state_e state_nx;

    logic [N-1:0]     a_sh;
    logic [N-1:0]     b_sh;
    logic [N-1:0]     res_sh;
    logic             borrow;
    logic [CNT_W-1:0] cnt;

    logic             bit_r;
    logic             bit_p;
    logic             accept;
    logic             last_step;

    sottrattore_1bit u_cell (
        .d     (bit_r),
        .p_out (bit_p),
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .p_in  (borrow)
    );

    assign last_step = (cnt == CNT_LAST);

    // State register; reset also aborts any subtraction in progress.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode plus the busy/done strobes and start acceptance.
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        accept   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = ST_CALC;
                end
            end
            ST_CALC: begin
                busy = 1'b1;
                if (last_step) begin
                    state_nx = ST_FINE;
                end
            end
            ST_FINE: begin
                done = 1'b1;
                if (start) begin
                    accept   = 1'b1;
                    state_nx = ST_CALC;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Operand capture and the serial shift path. Operands are latched only
    // on an accepted start, so a/b may change freely while busy.
    always_ff @(posedge clock) begin
        if (reset) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            res_sh <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
        end else if (state == ST_CALC) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= {bit_r, res_sh[N-1:1]};
            borrow <= bit_p;
            if (!last_step) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Result and flags change only on the final bit step, so the outputs
    // never show a partially built difference.
    always_ff @(posedge clock) begin
        if (reset) begin
            d        <= '0;
            prestito <= 1'b0;
            ovf      <= 1'b0;
        end else if ((state == ST_CALC) && last_step) begin
            d        <= {bit_r, res_sh[N-1:1]};
            prestito <= bit_p;
            // Signed overflow: borrow into the sign bit differs from the
            // borrow out of it.
            ovf      <= borrow ^ bit_p;
        end
    end

endmodule
